regfile_sort_ctrl: RTL and testbench

In-place ascending bubble-sort sequencer for the 16x8 register file (one combinational read port, one synchronous write port). On a Start pulse it drives the file's read and write ports to compare adjacent entries and swap out-of-order pairs. It terminates early when a pass makes no swaps, then pulses Done. It sits between the top-level control (buttons/FSM) and the register file, and owns both file ports while Busy.

---
 rtl/regfile_sort_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_regfile_sort_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sort_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_sort_ctrl
//
// In-place ascending bubble-sort sequencer for a 16x8 register file that has
// one combinational read port and one synchronous write port. After a Start
// pulse it walks adjacent pairs: it reads both entries, compares them unsigned,
// and writes them back swapped when they are out of order. A pass that makes
// no swap ends the sort early. Done pulses for one cycle at the end.
//
// Ports
//   Clk     in   1  rising-edge clock
//   Rst     in   1  synchronous active-high reset
//   Start   in   1  sort request, sampled only while idle
//   Busy    out  1  high from the first sort cycle through the Done cycle
//   Done    out  1  one-cycle completion pulse
//   Swaps   out  7  swaps made by the current/last sort, held after Done
//   R_Addr  out  4  register-file read address (0 when R_en is low)
//   R_en    out  1  register-file read enable
//   R_Data  in   8  register-file read data, combinational from R_Addr
//   W_Addr  out  4  register-file write address (0 when W_en is low)
//   W_en    out  1  register-file write enable
//   W_Data  out  8  register-file write data (0 when W_en is low)
//
// All port outputs are decoded from registered state only, so nothing on the
// output side depends combinationally on R_Data.
// -----------------------------------------------------------------------------
module regfile_sort_ctrl (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  output logic       Busy,
  output logic       Done,
  output logic [6:0] Swaps,
  output logic [3:0] R_Addr,
  output logic       R_en,
  input  logic [7:0] R_Data,
  output logic [3:0] W_Addr,
  output logic       W_en,
  output logic [7:0] W_Data
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_CMP  = 3'd3,
    S_WR_A = 3'd4,
    S_WR_B = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_pass;
  logic [3:0] w_pass_nxt;
  logic [3:0] r_idx;
  logic [3:0] w_idx_nxt;
  logic [7:0] r_a;
  logic [7:0] w_a_nxt;
  logic [7:0] r_b;
  logic [7:0] w_b_nxt;
  logic       r_swapped;
  logic       w_swapped_nxt;
  logic [6:0] r_swaps;
  logic [6:0] w_swaps_nxt;

  // Last pair of a pass: pass p only needs to reach idx 14-p, because every
  // earlier pass has already bubbled its largest value to the top.
  logic       w_pass_end;
  logic       w_last_pass;

  assign w_pass_end  = (r_idx >= (4'd14 - r_pass));
  assign w_last_pass = (r_pass == 4'd14);

  // State and datapath registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state   <= S_IDLE;
      r_pass    <= 4'd0;
      r_idx     <= 4'd0;
      r_a       <= 8'd0;
      r_b       <= 8'd0;
      r_swapped <= 1'b0;
      r_swaps   <= 7'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_pass    <= w_pass_nxt;
      r_idx     <= w_idx_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_swapped <= w_swapped_nxt;
      r_swaps   <= w_swaps_nxt;
    end
  end

  // Next-state and datapath update logic
  always_comb begin
    w_state_nxt   = r_state;
    w_pass_nxt    = r_pass;
    w_idx_nxt     = r_idx;
    w_a_nxt       = r_a;
    w_b_nxt       = r_b;
    w_swapped_nxt = r_swapped;
    w_swaps_nxt   = r_swaps;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_pass_nxt    = 4'd0;
          w_idx_nxt     = 4'd0;
          w_swapped_nxt = 1'b0;
          w_swaps_nxt   = 7'd0;
          w_state_nxt   = S_RD_A;
        end else begin
          w_state_nxt   = S_IDLE;
        end
      end
      S_RD_A: begin
        w_a_nxt     = R_Data;
        w_state_nxt = S_RD_B;
      end
      S_RD_B: begin
        w_b_nxt     = R_Data;
        w_state_nxt = S_CMP;
      end
      S_CMP: begin
        // Equal values are left in place, which keeps the sort stable.
        if (r_a > r_b) begin
          w_state_nxt = S_WR_A;
        end else if (!w_pass_end) begin
          w_idx_nxt   = r_idx + 4'd1;
          w_state_nxt = S_RD_A;
        end else if (w_last_pass || !r_swapped) begin
          w_state_nxt = S_DONE;
        end else begin
          w_pass_nxt    = r_pass + 4'd1;
          w_idx_nxt     = 4'd0;
          w_swapped_nxt = 1'b0;
          w_state_nxt   = S_RD_A;
        end
      end
      S_WR_A: begin
        w_state_nxt = S_WR_B;
      end
      S_WR_B: begin
        w_swapped_nxt = 1'b1;
        w_swaps_nxt   = r_swaps + 7'd1;
        // This pass just swapped, so only the pass limit can end the sort here.
        if (!w_pass_end) begin
          w_idx_nxt   = r_idx + 4'd1;
          w_state_nxt = S_RD_A;
        end else if (w_last_pass) begin
          w_state_nxt = S_DONE;
        end else begin
          w_pass_nxt    = r_pass + 4'd1;
          w_idx_nxt     = 4'd0;
          w_swapped_nxt = 1'b0;
          w_state_nxt   = S_RD_A;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Port decode from registered state, index and operands
  always_comb begin
    R_en   = 1'b0;
    R_Addr = 4'd0;
    W_en   = 1'b0;
    W_Addr = 4'd0;
    W_Data = 8'd0;
    case (r_state)
      S_RD_A: begin
        R_en   = 1'b1;
        R_Addr = r_idx;
      end
      S_RD_B: begin
        R_en   = 1'b1;
        R_Addr = r_idx + 4'd1;
      end
      S_WR_A: begin
        W_en   = 1'b1;
        W_Addr = r_idx;
        W_Data = r_b;
      end
      S_WR_B: begin
        W_en   = 1'b1;
        W_Addr = r_idx + 4'd1;
        W_Data = r_a;
      end
      default: begin
        R_en = 1'b0;
      end
    endcase
  end

  assign Busy  = (r_state != S_IDLE);
  assign Done  = (r_state == S_DONE);
  assign Swaps = r_swaps;

endmodule

// File: tb/tb_regfile_sort_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regfile_sort_ctrl
//
// Bench for regfile_sort_ctrl. It models the 16x8 register file (combinational
// read, synchronous write, reloaded from a preload image while Rst is high).
// Each sort queues its expected result (swap count, optional cycle count,
// write-free flag, final file image); a monitor pops one entry per Done pulse.
// -----------------------------------------------------------------------------
module tb_regfile_sort_ctrl;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Start;
  logic       Busy;
  logic       Done;
  logic [6:0] Swaps;
  logic [3:0] R_Addr;
  logic       R_en;
  logic [7:0] R_Data;
  logic [3:0] W_Addr;
  logic       W_en;
  logic [7:0] W_Data;

  always #5 Clk = ~Clk;

  regfile_sort_ctrl dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .Start  (Start),
    .Busy   (Busy),
    .Done   (Done),
    .Swaps  (Swaps),
    .R_Addr (R_Addr),
    .R_en   (R_en),
    .R_Data (R_Data),
    .W_Addr (W_Addr),
    .W_en   (W_en),
    .W_Data (W_Data)
  );

  // register file model
  logic [7:0] mem [16];
  logic [7:0] preload [16];

  assign R_Data = R_en ? mem[R_Addr] : 8'h00;

  always @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= preload[i];
    end else if (W_en) begin
      mem[W_Addr] <= W_Data;
    end
  end

  typedef struct packed {
    logic [6:0]   swaps;
    logic [9:0]   cycles;
    logic         chk_cycles;
    logic         chk_nowrite;
    logic [127:0] data;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   busy_cnt = 0;
  int   wen_cnt  = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [127:0] pk(input logic [7:0] a [16]);
    logic [127:0] r;
    r = 128'd0;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = a[i];
    return r;
  endfunction

  task automatic push_exp(input int sw, input int cyc, input bit chk_c,
                          input bit chk_nw, input logic [7:0] sorted [16]);
    exp_t e;
    e.swaps       = 7'(sw);
    e.cycles      = 10'(cyc);
    e.chk_cycles  = chk_c;
    e.chk_nowrite = chk_nw;
    e.data        = pk(sorted);
    q.push_back(e);
  endtask

  // monitor: sample away from the active edge, compare on every Done pulse
  always @(negedge Clk) begin
    exp_t e;
    if (Rst || !Busy) begin
      busy_cnt = 0;
      wen_cnt  = 0;
    end else begin
      busy_cnt++;
      if (W_en) wen_cnt++;
      if (busy_cnt == 1) check("swaps_cleared_at_start", int'(Swaps), 0);
      if (Done) begin
        done_cnt++;
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=done required=no_done");
        end else begin
          e = q.pop_front();
          check("swaps", int'(Swaps), int'(e.swaps));
          if (e.chk_cycles) check("done_latency", busy_cnt, int'(e.cycles));
          if (e.chk_nowrite) check("w_en_count", wen_cnt, 0);
          for (int i = 0; i < 16; i++)
            check($sformatf("data[%0d]", i), int'(mem[i]), int'(e.data[i*8 +: 8]));
        end
      end
    end
  end

  task automatic load_and_reset(input logic [7:0] v [16]);
    for (int i = 0; i < 16; i++) preload[i] = v[i];
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
  endtask

  task automatic start_pulse();
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int base;
    int n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < maxc) begin
      @(posedge Clk); #1;
      n++;
    end
    if (done_cnt == base) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no_done required=done_within_%0d", maxc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] v_t1 [16];
    logic [7:0] s_t1 [16];
    logic [7:0] v_inc [16];
    logic [7:0] v_rev [16];
    logic [7:0] v_aa [16];
    logic [7:0] v_eq [16];
    logic [7:0] s_eq [16];

    v_t1 = '{8'd48, 8'd53, 8'd68, 8'd57, 8'd55, 8'd59, 8'd40, 8'd49,
             8'd31, 8'd38, 8'd54, 8'd50, 8'd63, 8'd58, 8'd70, 8'd51};
    s_t1 = '{8'd31, 8'd38, 8'd40, 8'd48, 8'd49, 8'd50, 8'd51, 8'd53,
             8'd54, 8'd55, 8'd57, 8'd58, 8'd59, 8'd63, 8'd68, 8'd70};
    v_eq = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h10, 8'h05, 8'h11, 8'h12,
             8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A};
    s_eq = '{8'h00, 8'h01, 8'h02, 8'h05, 8'h10, 8'h10, 8'h11, 8'h12,
             8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A};
    for (int i = 0; i < 16; i++) begin
      v_inc[i] = 8'(i);
      v_rev[i] = 8'(15 - i);
      v_aa[i]  = 8'hAA;
    end

    Start = 1'b0;
    Rst   = 1'b0;
    @(posedge Clk); #1;
    load_and_reset(v_t1);

    // reset state
    check("rst_busy",   int'(Busy),   0);
    check("rst_done",   int'(Done),   0);
    check("rst_swaps",  int'(Swaps),  0);
    check("rst_r_en",   int'(R_en),   0);
    check("rst_w_en",   int'(W_en),   0);
    check("rst_r_addr", int'(R_Addr), 0);
    check("rst_w_addr", int'(W_Addr), 0);
    check("rst_w_data", int'(W_Data), 0);

    // main preload: 54 swaps
    push_exp(54, 0, 1'b0, 1'b0, s_t1);
    start_pulse();
    wait_done(800);

    // pre-sorted: one pass, no writes
    load_and_reset(v_inc);
    push_exp(0, 46, 1'b1, 1'b1, v_inc);
    start_pulse();
    wait_done(100);

    // reversed: worst case
    load_and_reset(v_rev);
    push_exp(120, 601, 1'b1, 1'b0, v_inc);
    start_pulse();
    wait_done(700);

    // all equal: never swapped
    load_and_reset(v_aa);
    push_exp(0, 46, 1'b1, 1'b1, v_aa);
    start_pulse();
    wait_done(100);

    // equal pair at 3/4 with a smaller value behind it: 2 swaps over 3 passes
    load_and_reset(v_eq);
    push_exp(2, 131, 1'b1, 1'b0, s_eq);
    start_pulse();
    wait_done(200);

    // Start pulses while busy have no effect
    load_and_reset(v_rev);
    push_exp(120, 601, 1'b1, 1'b0, v_inc);
    start_pulse();
    repeat (10) @(posedge Clk);
    #1;
    start_pulse();
    repeat (200) @(posedge Clk);
    #1;
    start_pulse();
    wait_done(700);

    // Start held through Done restarts on the next idle cycle
    load_and_reset(v_t1);
    push_exp(54, 0, 1'b0, 1'b0, s_t1);
    push_exp(0, 46, 1'b1, 1'b1, s_t1);
    Start = 1'b1;
    wait_done(800);
    check("restart_idle_busy", int'(Busy), 0);
    @(posedge Clk); #1;
    Start = 1'b0;
    check("restart_busy", int'(Busy), 1);
    wait_done(100);

    // Rst during the second compare's WR_A cycle
    load_and_reset(v_rev);
    start_pulse();
    repeat (8) @(posedge Clk);
    #1;
    check("pre_rst_w_en",   int'(W_en),   1);
    check("pre_rst_w_addr", int'(W_Addr), 1);
    check("pre_rst_swaps",  int'(Swaps),  1);
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    check("post_rst_busy",  int'(Busy),  0);
    check("post_rst_w_en",  int'(W_en),  0);
    check("post_rst_r_en",  int'(R_en),  0);
    check("post_rst_swaps", int'(Swaps), 0);
    push_exp(120, 601, 1'b1, 1'b0, v_inc);
    start_pulse();
    wait_done(700);

    repeat (2) @(posedge Clk);
    #1;
    check("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
